// File: rtl/bram_player.sv
// bram_player
//   Scans a DEPTH x DATA_W block RAM with a prescaled address counter and
//   presents the read word on the board outputs. Four debounced buttons
//   control the scan: run/pause, single step (pause only), direction
//   toggle and rewind to address 0. While paused, a valid/ready write port
//   loads the RAM.
//
// Ports
//   clk       system clock
//   rst_n     synchronous reset, active low
//   btn       raw buttons, async, active high:
//             [0] run/pause, [1] step, [2] reverse, [3] rewind
//   wr_valid  write request
//   wr_ready  high while paused; a write happens on valid & ready
//   wr_addr   write address
//   wr_data   write data
//   rd_addr   current scan address
//   rd_data   RAM word at the previous cycle's rd_addr
//   rd_valid  one-cycle pulse when rd_data first shows a new address
//   running   1 = RUN, 0 = PAUSE
//   reverse   1 = scan address decrements
module bram_player #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned SHIFT      = 0,
    parameter int unsigned DEBOUNCE_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        btn,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              running,
    output logic              reverse
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    // The prescaler needs at least one bit to be declarable; with SHIFT=0
    // that bit is simply never incremented.
    localparam int unsigned PW = (SHIFT > 0) ? SHIFT : 1;
    localparam logic [DEBOUNCE_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Button synchroniser and debouncer
    // ------------------------------------------------------------------
    logic [3:0]                 btn_s1_q;
    logic [3:0]                 btn_s2_q;
    logic [3:0][DEBOUNCE_W-1:0] cnt_q, cnt_d;
    logic [3:0]                 db_q, db_d;
    logic [3:0]                 db_prev_q;
    logic [3:0]                 press;

    // A change of the synced level is visible one stage early (s1 != s2),
    // so the counter restarts on the same edge the synced level moves.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        for (int unsigned i = 0; i < 4; i++) begin
            if (btn_s1_q[i] != btn_s2_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != CNT_MAX) begin
                cnt_d[i] = cnt_q[i] + DEBOUNCE_W'(1);
            end else begin
                db_d[i] = btn_s2_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_s1_q  <= '0;
            btn_s2_q  <= '0;
            cnt_q     <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
        end else begin
            btn_s1_q  <= btn;
            btn_s2_q  <= btn_s1_q;
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
        end
    end

    assign press = db_q & ~db_prev_q;

    // ------------------------------------------------------------------
    // Run/pause FSM
    // ------------------------------------------------------------------
    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_PAUSE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_PAUSE: if (press[0]) state_d = ST_RUN;
            ST_RUN:   if (press[0]) state_d = ST_PAUSE;
            default:  state_d = ST_PAUSE;
        endcase
    end

    always_comb begin
        running  = (state_q == ST_RUN);
        wr_ready = (state_q == ST_PAUSE);
    end

    // ------------------------------------------------------------------
    // Prescaler and scan address
    // ------------------------------------------------------------------
    logic [PW-1:0]     pre_q, pre_d;
    logic              tick;
    logic              advance;
    logic              rewind;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rev_q, rev_d;
    logic              moved_q, moved_d;
    logic              rd_valid_q;

    always_comb begin
        pre_d = pre_q;
        tick  = 1'b0;
        if (state_q == ST_RUN) begin
            if (SHIFT == 0) begin
                tick = 1'b1;
            end else begin
                tick  = (pre_q == {PW{1'b1}});
                pre_d = pre_q + PW'(1);
            end
        end
        if (state_d != ST_RUN || rewind) begin
            pre_d = '0;
        end
    end

    // Direction toggles take effect after the current advance, so an
    // advance in the same cycle still uses the old direction.
    always_comb begin
        rewind  = press[3];
        advance = ((state_q == ST_RUN) && tick) ||
                  ((state_q == ST_PAUSE) && press[1]);
        rev_d   = rev_q ^ press[2];
        addr_d  = addr_q;
        if (rewind) begin
            addr_d = '0;
        end else if (advance) begin
            addr_d = rev_q ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));
        end
        moved_d = (addr_d != addr_q);
    end

    // moved_q marks "rd_addr just changed"; rd_valid follows one cycle
    // later, once the RAM has produced the word for the new address.
    // Reset counts as reaching address 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q      <= '0;
            addr_q     <= '0;
            rev_q      <= 1'b0;
            moved_q    <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            addr_q     <= addr_d;
            rev_q      <= rev_d;
            moved_q    <= moved_d;
            rd_valid_q <= moved_q;
        end
    end

    // ------------------------------------------------------------------
    // Block RAM: synchronous read-first, write only while paused
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic              wr_fire;

    assign wr_fire = rst_n && wr_valid && wr_ready;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= mem[addr_q];
    end

    assign rd_addr  = addr_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign reverse  = rev_q;

endmodule
